// File: rtl/uart_mem_bridge_pkg.sv
// Shared types and constants for the UART debug bridge into the instruction/data memories.
package uart_mem_bridge_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StCheck,
        StIssue,
        StWaitRsp,
        StSend
    } state_t;

    localparam int unsigned HdrRwBit    = 7;
    localparam int unsigned HdrMemBit   = 6;
    localparam int unsigned HdrAddr8Bit = 0;
    localparam logic [7:0]  HdrRsvdMask = 8'h3E;

    localparam logic [7:0]  AckByte = 8'h06;
    localparam logic [7:0]  NakByte = 8'h15;

    localparam int unsigned RespLen   = 6;
    localparam int unsigned WrDataLen = 4;

endpackage

// File: rtl/uart_resp_serializer.sv
// Shifts out a loaded 1- or 6-byte response MSB byte first over a valid/ready byte handshake.
module uart_resp_serializer
    import uart_mem_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [47:0] load_data,
    input  logic [2:0]  load_count,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        done
);

    logic [47:0] shift_q, shift_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        xfer;

    assign xfer = tx_valid && tx_ready;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (load) begin
            cnt_d = load_count;
            // A single-byte response sits in the low byte; move it to the output position.
            shift_d = (load_count == 3'd1) ? {load_data[7:0], {((RespLen - 1) * 8){1'b0}}}
                                           : load_data;
        end else if (xfer) begin
            cnt_d   = cnt_q - 3'd1;
            shift_d = {shift_q[39:0], 8'd0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign tx_valid = (cnt_q != 3'd0);
    assign tx_byte  = shift_q[47:40];
    assign done     = xfer && (cnt_q == 3'd1);

endmodule

// File: rtl/uart_mem_bridge.sv
// UART command engine: parses read/write frames, drives the memory debug bus, returns ACK/NAK/data.
module uart_mem_bridge
    import uart_mem_bridge_pkg::*;
#(
    parameter int unsigned RESP_TIMEOUT  = 16,
    parameter int unsigned FRAME_TIMEOUT = 100000,
    parameter int unsigned TO_W          = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic        cpu_enable,
    output logic        write_mem_req,
    output logic        target_mem_type,
    output logic [8:0]  target_addr,
    output logic        rw_flag,
    output logic [31:0] uart_rx_data_out,
    input  logic        instr_mem_tx_data_ready,
    input  logic [41:0] instr_mem_tx_data_in,
    input  logic        data_mem_tx_data_ready,
    input  logic [41:0] data_mem_tx_data_in,
    output logic        busy,
    output logic [1:0]  err_sticky
);

    state_t          state_q, state_d;
    logic            rw_q, rw_d, mem_q, mem_d;
    logic [8:0]      addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [1:0]      bcnt_q, bcnt_d;
    logic [TO_W-1:0] to_q, to_d;
    logic [1:0]      err_q, err_d;

    logic            ld;
    logic [47:0]     ld_data;
    logic [2:0]      ld_count;
    logic            ser_done;

    logic            rsp_ready;
    logic [41:0]     rsp_data;

    // Only the memory addressed by the frame is listened to.
    assign rsp_ready = mem_q ? instr_mem_tx_data_ready : data_mem_tx_data_ready;
    assign rsp_data  = mem_q ? instr_mem_tx_data_in : data_mem_tx_data_in;

    always_comb begin
        state_d  = state_q;
        rw_d     = rw_q;
        mem_d    = mem_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        bcnt_d   = bcnt_q;
        to_d     = to_q;
        err_d    = err_q;
        ld       = 1'b0;
        ld_data  = '0;
        ld_count = 3'd1;

        unique case (state_q)
            StIdle: begin
                if (rx_valid) begin
                    rw_d      = rx_byte[HdrRwBit];
                    mem_d     = rx_byte[HdrMemBit];
                    addr_d[8] = rx_byte[HdrAddr8Bit];
                    to_d      = '0;
                    bcnt_d    = '0;
                    if ((rx_byte & HdrRsvdMask) != 8'd0) begin
                        ld      = 1'b1;
                        ld_data = {40'd0, NakByte};
                        state_d = StSend;
                    end else begin
                        state_d = StAddr;
                    end
                end
            end
            StAddr, StData: begin
                if (rx_valid) begin
                    to_d = '0;
                    if (state_q == StAddr) begin
                        addr_d[7:0] = rx_byte;
                        state_d     = rw_q ? StData : StCheck;
                    end else begin
                        wdata_d = {wdata_q[23:0], rx_byte};
                        bcnt_d  = bcnt_q + 2'd1;
                        if (bcnt_q == 2'(WrDataLen - 1)) begin
                            state_d = StCheck;
                        end
                    end
                end else if (to_q == TO_W'(FRAME_TIMEOUT - 1)) begin
                    err_d[1] = 1'b1;
                    state_d  = StIdle;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            StCheck: begin
                to_d = '0;
                if (cpu_enable) begin
                    ld      = 1'b1;
                    ld_data = {40'd0, NakByte};
                    state_d = StSend;
                end else begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                // The response timeout runs from the issue cycle itself.
                to_d = to_q + TO_W'(1);
                if (rw_q) begin
                    ld      = 1'b1;
                    ld_data = {40'd0, AckByte};
                    state_d = StSend;
                end else begin
                    state_d = StWaitRsp;
                end
            end
            StWaitRsp: begin
                if (rsp_ready) begin
                    ld       = 1'b1;
                    ld_data  = {6'd0, rsp_data};
                    ld_count = 3'(RespLen);
                    state_d  = StSend;
                end else if (to_q == TO_W'(RESP_TIMEOUT - 1)) begin
                    ld      = 1'b1;
                    ld_data = {40'd0, NakByte};
                    state_d = StSend;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            StSend: begin
                if (ser_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (rx_valid && !(state_q inside {StIdle, StAddr, StData})) begin
            err_d[0] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            rw_q    <= 1'b0;
            mem_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            bcnt_q  <= '0;
            to_q    <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            mem_q   <= mem_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            bcnt_q  <= bcnt_d;
            to_q    <= to_d;
            err_q   <= err_d;
        end
    end

    assign write_mem_req    = (state_q == StIssue);
    assign target_mem_type  = mem_q;
    assign target_addr      = addr_q;
    assign rw_flag          = rw_q;
    assign uart_rx_data_out = wdata_q;
    assign busy             = (state_q != StIdle);
    assign err_sticky       = err_q;

    uart_resp_serializer u_ser (
        .clk        (clk),
        .reset      (reset),
        .load       (ld),
        .load_data  (ld_data),
        .load_count (ld_count),
        .tx_byte    (tx_byte),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .done       (ser_done)
    );

endmodule
